// File: rtl/rs_age_sel.sv
// rs_age_sel: reservation station with oldest-first wakeup/select.
//
// Accepts up to DW ops per cycle from rename/dispatch. Source readiness is
// tracked against NCDB CDB broadcasts, with a same-cycle bypass into select.
// Up to IW ready ops are issued per cycle in strict age order. Flush discards
// every entry.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          discard all entries; blocks dispatch and issue this cycle
//   disp_*         DW dispatch slots (valid, rdy, source tags/ready, payload)
//   cdb_en/tag     NCDB result broadcasts
//   fu_rdy         per-port FU availability
//   iss_*          IW issue ports (valid, payload, regfile read tags)
//   free_count     registered number of empty entries
module rs_age_sel #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 2,
    parameter int unsigned IW    = 2,
    parameter int unsigned NCDB  = 4,
    parameter int unsigned TAGW  = 7,
    parameter int unsigned PW    = 64,
    localparam int unsigned FCW  = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DW-1:0]              disp_valid,
    output logic [DW-1:0]              disp_rdy,
    input  logic [DW-1:0][TAGW-1:0]    disp_rs1_tag,
    input  logic [DW-1:0][TAGW-1:0]    disp_rs2_tag,
    input  logic [DW-1:0]              disp_rs1_rdy,
    input  logic [DW-1:0]              disp_rs2_rdy,
    input  logic [DW-1:0][PW-1:0]      disp_payload,
    input  logic [NCDB-1:0]            cdb_en,
    input  logic [NCDB-1:0][TAGW-1:0]  cdb_tag,
    input  logic [IW-1:0]              fu_rdy,
    output logic [IW-1:0]              iss_valid,
    output logic [IW-1:0][PW-1:0]      iss_payload,
    output logic [IW-1:0][TAGW-1:0]    iss_rs1_tag,
    output logic [IW-1:0][TAGW-1:0]    iss_rs2_tag,
    output logic [FCW-1:0]             free_count
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
    logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
    logic [TAGW-1:0]  rs1_tag_q [DEPTH];
    logic [TAGW-1:0]  rs1_tag_d [DEPTH];
    logic [TAGW-1:0]  rs2_tag_q [DEPTH];
    logic [TAGW-1:0]  rs2_tag_d [DEPTH];
    logic [PW-1:0]    payload_q [DEPTH];
    logic [PW-1:0]    payload_d [DEPTH];
    // older_q[i][j] = 1 when entry i was dispatched before entry j.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [FCW-1:0]   free_count_q, free_count_d;

    logic [DEPTH-1:0] rs1_eff, rs2_eff, cand, issue_mask, new_mask;
    int unsigned      rank [DEPTH];
    int unsigned      slot_of [DEPTH];

    function automatic logic cdb_hit(input logic [TAGW-1:0]             tag,
                                     input logic [NCDB-1:0]             en,
                                     input logic [NCDB-1:0][TAGW-1:0]   tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < NCDB; c++) begin
            if (en[c] && tags[c] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    assign free_count = free_count_q;

    always_comb begin
        for (int k = 0; k < DW; k++) begin
            disp_rdy[k] = (int'(free_count_q) > k) && !flush;
        end
    end

    // Effective readiness includes this cycle's broadcasts.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rs1_eff[i] = rs1_rdy_q[i] | cdb_hit(rs1_tag_q[i], cdb_en, cdb_tag);
            rs2_eff[i] = rs2_rdy_q[i] | cdb_hit(rs2_tag_q[i], cdb_en, cdb_tag);
        end
        cand = valid_q & rs1_eff & rs2_eff;
    end

    // Age rank among candidates: 0 is the oldest ready entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rank[i] = 0;
            for (int k = 0; k < DEPTH; k++) begin
                if (k != i && cand[k] && older_q[k][i]) rank[i]++;
            end
        end
    end

    // The r-th oldest candidate goes to the r-th port that has fu_rdy set.
    always_comb begin
        int unsigned port_rank;
        port_rank   = 0;
        iss_valid   = '0;
        iss_payload = '0;
        iss_rs1_tag = '0;
        iss_rs2_tag = '0;
        issue_mask  = '0;
        for (int j = 0; j < IW; j++) begin
            if (fu_rdy[j] && !flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cand[i] && rank[i] == port_rank) begin
                        iss_valid[j]   = 1'b1;
                        iss_payload[j] = payload_q[i];
                        iss_rs1_tag[j] = rs1_tag_q[i];
                        iss_rs2_tag[j] = rs2_tag_q[i];
                        issue_mask[i]  = 1'b1;
                    end
                end
                port_rank++;
            end
        end
    end

    always_comb begin
        logic [DEPTH-1:0] taken;
        logic             found;
        int               n_acc, n_iss;
        valid_d   = valid_q;
        rs1_rdy_d = rs1_eff;
        rs2_rdy_d = rs2_eff;
        rs1_tag_d = rs1_tag_q;
        rs2_tag_d = rs2_tag_q;
        payload_d = payload_q;
        older_d   = older_q;
        taken     = '0;
        found     = 1'b0;
        new_mask  = '0;
        n_acc     = 0;
        n_iss     = 0;
        for (int i = 0; i < DEPTH; i++) slot_of[i] = 0;

        for (int i = 0; i < DEPTH; i++) begin
            if (issue_mask[i]) begin
                valid_d[i]   = 1'b0;
                rs1_rdy_d[i] = 1'b0;
                rs2_rdy_d[i] = 1'b0;
                n_iss++;
            end
        end

        // Slot k claims the k-th lowest empty entry (by registered state).
        for (int k = 0; k < DW; k++) begin
            found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && !valid_q[i] && !taken[i]) begin
                    found    = 1'b1;
                    taken[i] = 1'b1;
                    if (disp_valid[k] && disp_rdy[k]) begin
                        new_mask[i]  = 1'b1;
                        slot_of[i]   = k;
                        valid_d[i]   = 1'b1;
                        rs1_tag_d[i] = disp_rs1_tag[k];
                        rs2_tag_d[i] = disp_rs2_tag[k];
                        payload_d[i] = disp_payload[k];
                        rs1_rdy_d[i] = disp_rs1_rdy[k] |
                                       cdb_hit(disp_rs1_tag[k], cdb_en, cdb_tag);
                        rs2_rdy_d[i] = disp_rs2_rdy[k] |
                                       cdb_hit(disp_rs2_tag[k], cdb_en, cdb_tag);
                        n_acc++;
                    end
                end
            end
        end

        // New entries are younger than everything resident; lower slot is older.
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (new_mask[i] && new_mask[j]) begin
                    older_d[i][j] = slot_of[i] < slot_of[j];
                end else if (new_mask[i]) begin
                    older_d[i][j] = 1'b0;
                end else if (new_mask[j]) begin
                    older_d[i][j] = 1'b1;
                end
            end
        end

        free_count_d = FCW'(int'(free_count_q) - n_acc + n_iss);

        if (flush) begin
            valid_d      = '0;
            free_count_d = FCW'(DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            rs1_rdy_q    <= '0;
            rs2_rdy_q    <= '0;
            free_count_q <= FCW'(DEPTH);
        end else begin
            valid_q      <= valid_d;
            rs1_rdy_q    <= rs1_rdy_d;
            rs2_rdy_q    <= rs2_rdy_d;
            free_count_q <= free_count_d;
        end
    end

    // Entry contents are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clk) begin
        rs1_tag_q <= rs1_tag_d;
        rs2_tag_q <= rs2_tag_d;
        payload_q <= payload_d;
        older_q   <= older_d;
    end

    // Dispatch requests must be packed from slot 0.
    disp_contiguous: assert property (@(posedge clk) disable iff (rst)
        (disp_valid & (disp_valid + DW'(1))) == '0);

endmodule

// File: tb/tb_rs_age_sel.sv
module tb_rs_age_sel;

    localparam int DEPTH = 16;

    logic             clk, rst, flush;
    logic [1:0]       disp_valid, disp_rdy;
    logic [1:0][6:0]  disp_rs1_tag, disp_rs2_tag;
    logic [1:0]       disp_rs1_rdy, disp_rs2_rdy;
    logic [1:0][63:0] disp_payload;
    logic [3:0]       cdb_en;
    logic [3:0][6:0]  cdb_tag;
    logic [1:0]       fu_rdy, iss_valid;
    logic [1:0][63:0] iss_payload;
    logic [1:0][6:0]  iss_rs1_tag, iss_rs2_tag;
    logic [4:0]       free_count;

    int checks = 0;
    int passed = 0;

    rs_age_sel dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_rdy     (disp_rdy),
        .disp_rs1_tag (disp_rs1_tag),
        .disp_rs2_tag (disp_rs2_tag),
        .disp_rs1_rdy (disp_rs1_rdy),
        .disp_rs2_rdy (disp_rs2_rdy),
        .disp_payload (disp_payload),
        .cdb_en       (cdb_en),
        .cdb_tag      (cdb_tag),
        .fu_rdy       (fu_rdy),
        .iss_valid    (iss_valid),
        .iss_payload  (iss_payload),
        .iss_rs1_tag  (iss_rs1_tag),
        .iss_rs2_tag  (iss_rs2_tag),
        .free_count   (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        flush        = 1'b0;
        disp_valid   = '0;
        disp_rs1_tag = '0;
        disp_rs2_tag = '0;
        disp_rs1_rdy = '0;
        disp_rs2_rdy = '0;
        disp_payload = '0;
        cdb_en       = '0;
        cdb_tag      = '0;
    endtask

    task automatic set_slot(input int k, input logic [6:0] t1, input logic r1,
                            input logic [6:0] t2, input logic r2, input logic [63:0] pl);
        disp_rs1_tag[k] = t1;
        disp_rs1_rdy[k] = r1;
        disp_rs2_tag[k] = t2;
        disp_rs2_rdy[k] = r2;
        disp_payload[k] = pl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        fu_rdy = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (free_count !== 5'd16) $display("FAIL reset_free: got %0d want 16", free_count);
        else passed++;
        checks++;
        if (disp_rdy !== 2'b11) $display("FAIL reset_disp_rdy: got %b want 11", disp_rdy);
        else passed++;
        checks++;
        if (iss_valid !== 2'b00) $display("FAIL reset_iss_valid: got %b want 00", iss_valid);
        else passed++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        idle();
        fu_rdy = 2'b11;
        set_slot(0, 7'd1, 1'b1, 7'd2, 1'b1, 64'hA0);
        set_slot(1, 7'd3, 1'b1, 7'd4, 1'b1, 64'hA1);
        disp_valid = 2'b11;
        #1;
        checks++;
        if (iss_valid !== 2'b00) $display("FAIL basic_same_cycle: got %b want 00", iss_valid);
        else passed++;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (iss_valid !== 2'b11) $display("FAIL basic_iss_valid: got %b want 11", iss_valid);
        else passed++;
        checks++;
        if (iss_payload[0] !== 64'hA0 || iss_payload[1] !== 64'hA1)
            $display("FAIL basic_payload: got %0h/%0h want a0/a1", iss_payload[0], iss_payload[1]);
        else passed++;
        checks++;
        if (iss_rs1_tag[0] !== 7'd1 || iss_rs2_tag[1] !== 7'd4)
            $display("FAIL basic_tags: got %0d/%0d want 1/4", iss_rs1_tag[0], iss_rs2_tag[1]);
        else passed++;
        checks++;
        if (free_count !== 5'd14) $display("FAIL basic_free_mid: got %0d want 14", free_count);
        else passed++;
        @(negedge clk);
        #1;
        checks++;
        if (free_count !== 5'd16 || iss_valid !== 2'b00)
            $display("FAIL basic_drained: got %0d/%b want 16/00", free_count, iss_valid);
        else passed++;
    endtask

    task automatic test_cdb_wakeup();
        @(negedge clk);
        idle();
        fu_rdy = 2'b01;
        set_slot(0, 7'd5, 1'b0, 7'd6, 1'b1, 64'hB0);
        set_slot(1, 7'd7, 1'b1, 7'd8, 1'b1, 64'hB1);
        disp_valid = 2'b11;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (iss_valid !== 2'b01 || iss_payload[0] !== 64'hB1)
            $display("FAIL wake_b_first: got %b/%0h want 01/b1", iss_valid, iss_payload[0]);
        else passed++;
        @(negedge clk);
        idle();
        cdb_en = 4'b0100;
        cdb_tag[2] = 7'd5;
        #1;
        checks++;
        if (iss_valid !== 2'b01 || iss_payload[0] !== 64'hB0)
            $display("FAIL wake_bypass: got %b/%0h want 01/b0", iss_valid, iss_payload[0]);
        else passed++;
        checks++;
        if (iss_rs1_tag[0] !== 7'd5 || free_count !== 5'd15)
            $display("FAIL wake_tag_free: got %0d/%0d want 5/15", iss_rs1_tag[0], free_count);
        else passed++;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (free_count !== 5'd16 || iss_valid !== 2'b00)
            $display("FAIL wake_drained: got %0d/%b want 16/00", free_count, iss_valid);
        else passed++;
    endtask

    task automatic test_full();
        int order[$];
        int idx;
        for (int n = 0; n < 16; n += 2) begin
            @(negedge clk);
            idle();
            fu_rdy = 2'b11;
            for (int k = 0; k < 2; k++) begin
                set_slot(k, (n + k == 2 || n + k == 5 || n + k == 9) ? 7'd30 : 7'd40,
                         1'b0, 7'd1, 1'b1, 64'h300 + 64'(n + k));
            end
            disp_valid = 2'b11;
        end
        @(negedge clk);
        idle();
        fu_rdy = 2'b11;
        set_slot(0, 7'd1, 1'b1, 7'd1, 1'b1, 64'hDEAD);
        set_slot(1, 7'd1, 1'b1, 7'd1, 1'b1, 64'hBEEF);
        disp_valid = 2'b11;
        cdb_en = 4'b0001;
        cdb_tag[0] = 7'd30;
        #1;
        checks++;
        if (free_count !== 5'd0 || disp_rdy !== 2'b00)
            $display("FAIL full_state: got %0d/%b want 0/00", free_count, disp_rdy);
        else passed++;
        checks++;
        if (iss_valid !== 2'b11 || iss_payload[0] !== 64'h302 || iss_payload[1] !== 64'h305)
            $display("FAIL full_issue: got %b/%0h/%0h want 11/302/305",
                     iss_valid, iss_payload[0], iss_payload[1]);
        else passed++;
        @(negedge clk);
        idle();
        fu_rdy = 2'b11;
        #1;
        checks++;
        if (free_count !== 5'd2 || disp_rdy !== 2'b11)
            $display("FAIL full_reopen: got %0d/%b want 2/11", free_count, disp_rdy);
        else passed++;
        checks++;
        if (iss_valid !== 2'b01 || iss_payload[0] !== 64'h309)
            $display("FAIL full_third: got %b/%0h want 01/309", iss_valid, iss_payload[0]);
        else passed++;
        for (int n = 0; n < 16; n++) begin
            if (n != 2 && n != 5 && n != 9) order.push_back(n);
        end
        idx = 0;
        while (idx < order.size()) begin
            @(negedge clk);
            idle();
            fu_rdy = 2'b11;
            cdb_en = 4'b0001;
            cdb_tag[0] = 7'd40;
            #1;
            checks++;
            if (iss_payload[0] !== 64'h300 + 64'(order[idx]))
                $display("FAIL full_drain_p0: got %0h want %0h", iss_payload[0],
                         64'h300 + 64'(order[idx]));
            else passed++;
            if (idx + 1 < order.size()) begin
                checks++;
                if (iss_valid !== 2'b11 || iss_payload[1] !== 64'h300 + 64'(order[idx + 1]))
                    $display("FAIL full_drain_p1: got %b/%0h want 11/%0h", iss_valid,
                             iss_payload[1], 64'h300 + 64'(order[idx + 1]));
                else passed++;
            end else begin
                checks++;
                if (iss_valid !== 2'b01) $display("FAIL full_drain_last: got %b want 01", iss_valid);
                else passed++;
            end
            idx += 2;
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (free_count !== 5'd16 || iss_valid !== 2'b00)
            $display("FAIL full_drained: got %0d/%b want 16/00", free_count, iss_valid);
        else passed++;
    endtask

    task automatic test_dispatch_capture();
        @(negedge clk);
        idle();
        fu_rdy = 2'b10;
        set_slot(0, 7'd9, 1'b0, 7'd10, 1'b1, 64'hC0);
        disp_valid = 2'b01;
        cdb_en = 4'b0001;
        cdb_tag[0] = 7'd9;
        #1;
        checks++;
        if (iss_valid !== 2'b00) $display("FAIL capture_same_cycle: got %b want 00", iss_valid);
        else passed++;
        @(negedge clk);
        idle();
        fu_rdy = 2'b10;
        #1;
        checks++;
        if (iss_valid !== 2'b10 || iss_payload[1] !== 64'hC0)
            $display("FAIL capture_issue_port1: got %b/%0h want 10/c0", iss_valid, iss_payload[1]);
        else passed++;
        checks++;
        if (iss_payload[0] !== 64'h0) $display("FAIL capture_idle_zero: got %0h want 0", iss_payload[0]);
        else passed++;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (free_count !== 5'd16) $display("FAIL capture_drained: got %0d want 16", free_count);
        else passed++;
    endtask

    task automatic test_flush();
        for (int n = 0; n < 5; n += 2) begin
            @(negedge clk);
            idle();
            fu_rdy = 2'b00;
            set_slot(0, 7'd1, 1'b1, 7'd1, 1'b1, 64'h500 + 64'(n));
            set_slot(1, 7'd1, 1'b1, 7'd1, 1'b1, 64'h501 + 64'(n));
            disp_valid = (n == 4) ? 2'b01 : 2'b11;
        end
        @(negedge clk);
        idle();
        fu_rdy = 2'b00;
        #1;
        checks++;
        if (free_count !== 5'd11 || iss_valid !== 2'b00)
            $display("FAIL flush_pre: got %0d/%b want 11/00", free_count, iss_valid);
        else passed++;
        @(negedge clk);
        idle();
        fu_rdy = 2'b11;
        flush = 1'b1;
        set_slot(0, 7'd1, 1'b1, 7'd1, 1'b1, 64'h5F0);
        set_slot(1, 7'd1, 1'b1, 7'd1, 1'b1, 64'h5F1);
        disp_valid = 2'b11;
        #1;
        checks++;
        if (iss_valid !== 2'b00 || disp_rdy !== 2'b00)
            $display("FAIL flush_cycle: got %b/%b want 00/00", iss_valid, disp_rdy);
        else passed++;
        @(negedge clk);
        idle();
        fu_rdy = 2'b11;
        #1;
        checks++;
        if (free_count !== 5'd16 || iss_valid !== 2'b00)
            $display("FAIL flush_after: got %0d/%b want 16/00", free_count, iss_valid);
        else passed++;
    endtask

    typedef struct {
        logic [63:0] pl;
        logic [6:0]  tag;
        logic        rdy;
        logic        gone;
    } mop_t;

    task automatic test_age_scoreboard();
        mop_t        q[$];
        mop_t        nq[$];
        mop_t        m;
        int          sent, nd, free_exp, pos, cyc;
        logic        cen;
        logic [6:0]  ctag;
        logic [1:0]  exp_valid;
        logic [63:0] exp_pl [2];
        sent = 0;
        cyc  = 0;
        while (sent < 40 || q.size() != 0) begin
            if (cyc == 3000) begin
                checks++;
                $display("FAIL age_timeout: got %0d pending want 0", q.size());
                break;
            end
            cyc++;
            @(negedge clk);
            idle();
            free_exp = DEPTH - q.size();
            nd = $urandom_range(0, 2);
            if (nd > free_exp) nd = free_exp;
            if (nd > 40 - sent) nd = 40 - sent;
            fu_rdy = 2'($urandom_range(0, 3));
            cen    = ($urandom_range(0, 2) == 0);
            ctag   = 7'(60 + $urandom_range(0, 3));
            for (int k = 0; k < nd; k++) begin
                set_slot(k, 7'(60 + (sent + k) % 4), ((sent + k) % 3) == 0, 7'd1, 1'b1,
                         64'h1000 + 64'(sent + k));
            end
            disp_valid = (nd == 0) ? 2'b00 : (nd == 1) ? 2'b01 : 2'b11;
            cdb_en     = {3'b000, cen};
            cdb_tag[0] = ctag;
            #1;
            checks++;
            if (free_count !== 5'(free_exp) || disp_rdy !== {free_exp > 1, free_exp > 0})
                $display("FAIL age_free: got %0d/%b want %0d", free_count, disp_rdy, free_exp);
            else passed++;
            exp_valid = 2'b00;
            exp_pl[0] = '0;
            exp_pl[1] = '0;
            pos = 0;
            for (int j = 0; j < 2; j++) begin
                if (fu_rdy[j]) begin
                    while (pos < q.size() && !(q[pos].rdy || (cen && q[pos].tag == ctag))) pos++;
                    if (pos < q.size()) begin
                        exp_valid[j] = 1'b1;
                        exp_pl[j]    = q[pos].pl;
                        q[pos].gone  = 1'b1;
                        pos++;
                    end
                end
            end
            checks++;
            if (iss_valid !== exp_valid ||
                (exp_valid[0] && iss_payload[0] !== exp_pl[0]) ||
                (exp_valid[1] && iss_payload[1] !== exp_pl[1]))
                $display("FAIL age_order: got %b/%0h/%0h want %b/%0h/%0h", iss_valid,
                         iss_payload[0], iss_payload[1], exp_valid, exp_pl[0], exp_pl[1]);
            else passed++;
            nq.delete();
            foreach (q[i]) begin
                if (!q[i].gone) begin
                    m = q[i];
                    m.rdy = m.rdy | (cen && m.tag == ctag);
                    nq.push_back(m);
                end
            end
            for (int k = 0; k < nd; k++) begin
                m.pl   = 64'h1000 + 64'(sent + k);
                m.tag  = 7'(60 + (sent + k) % 4);
                m.rdy  = (((sent + k) % 3) == 0) || (cen && m.tag == ctag);
                m.gone = 1'b0;
                nq.push_back(m);
            end
            q = nq;
            sent += nd;
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (free_count !== 5'd16) $display("FAIL age_drained: got %0d want 16", free_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cdb_wakeup();
        test_full();
        test_dispatch_capture();
        test_flush();
        test_age_scoreboard();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rs_age_sel.md
Name: rs_age_sel

Overview:
Parametrised reservation station with oldest-first wakeup/select. It sits between rename/dispatch and the execution units. It accepts up to DW ops per cycle, tracks source readiness from NCDB CDB broadcasts with same-cycle bypass, and issues up to IW ready ops per cycle in strict age order. Flush support is used for branch recovery.

Parameters:
DEPTH, 16, number of entries (power of 2 not required, >= 2)
DW, 2, dispatch width (ops accepted per cycle)
IW, 2, issue width (FU ports)
NCDB, 4, CDB broadcast ports
TAGW, 7, physical register tag width
PW, 64, opaque payload width (packed instruction packet)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  recovery: discard all entries
disp_valid  in  DW  dispatch request per slot; must be contiguous from slot 0
disp_rdy  out  DW  slot k may dispatch this cycle
disp_rs1_tag, disp_rs2_tag  in  DW x TAGW  source tags
disp_rs1_rdy, disp_rs2_rdy  in  DW  source already ready at rename (busy-bit table)
disp_payload  in  DW x PW  op packet
cdb_en  in  NCDB  broadcast valid
cdb_tag  in  NCDB x TAGW  broadcast tag
fu_rdy  in  IW  FU port j can accept an op this cycle
iss_valid  out  IW  port j issues this cycle
iss_payload  out  IW x PW  issued op packet
iss_rs1_tag, iss_rs2_tag  out  IW x TAGW  regfile read addresses for issued op
free_count  out  clog2(DEPTH+1)  registered number of empty entries

Behaviour:
- State per entry: valid, rs1_rdy, rs2_rdy, rs1_tag, rs2_tag, payload. Age matrix older[i][j] = 1 when entry i was dispatched before entry j.
- Reset/flush: all valid=0 at next edge. After the edge: free_count=DEPTH, disp_rdy=all 1 (if DEPTH>=DW), iss_valid=0. During the flush cycle, iss_valid is forced to 0 and dispatches are dropped. rst has priority over flush.
- disp_rdy[k] = (free_count > k) && !flush. The count is registered occupancy. Slots freed by issue in cycle N are not reusable until N+1.
- Dispatch slot k writes the k-th lowest-indexed empty entry. Within a cycle, slot k is older than slot k+1. All new entries are younger than all existing entries; update the age matrix row/column on write.
- Wakeup: a source is effectively ready if its stored rdy bit is set, or if any cdb_en[c] has cdb_tag[c]==tag this cycle (combinational bypass into select). The rdy bit latches at the edge.
- Dispatch-time capture: if a dispatching source tag matches an active CDB in the same cycle, it is stored as ready even when disp_rsX_rdy=0.
- Select: an entry is a candidate when valid and both sources are effectively ready.
  - The oldest candidate goes to the lowest-indexed port with fu_rdy=1, the next oldest to the next such port, and so on.
  - Ports with fu_rdy=0 are skipped and iss_valid=0 on them.
  - An entry is never issued on two ports.
- Issue latency: an op dispatched at edge N with ready sources is eligible in cycle N+1. An op woken by the CDB in cycle M may issue in cycle M.
- Issued entries clear valid and rdy bits at the edge. free_count' = free_count - accepted dispatches + issues.
- iss_* outputs are combinational from current state and CDB. When iss_valid=0 they are don't-care, but must drive defined values (0).
- Full: free_count=0 -> disp_rdy=0, and issue still proceeds. Empty: iss_valid=0.
- disp_valid[k]=1 with disp_rdy[k]=0 is ignored (no write). A non-contiguous disp_valid is illegal (assertion).

Test Plan:
1. Reset, dispatch 2 ops with ready sources, fu_rdy=11 -> both issue next cycle (op0 on port0, op1 on port1), free_count returns to 16.
2. Dispatch A(rs1 tag 5, not ready), then B ready, fu_rdy=01 -> B issues. Next cycle cdb_en[2], tag 5 -> A issues in the same cycle on port0.
3. Fill 16 entries with unready sources -> free_count=0, disp_rdy=00. Broadcast tag wakes 3 entries with fu_rdy=11 -> the two oldest issue, disp_rdy stays 00 that cycle, then becomes 11.
4. Dispatch an op with disp_rs1_rdy=0 and tag 9 while cdb_tag[0]=9 is active -> the op issues the following cycle with no further broadcast.
5. 5 entries valid, flush=1 with disp_valid=11 and ready ops -> iss_valid=00. Next cycle free_count=16, no stale issue.
6. Age wrap: dispatch/issue 40 ops of interleaved readiness, randomised fu_rdy -> the issue order of simultaneously ready entries always matches dispatch order (scoreboard check).
